ula_seq: RTL and testbench
==========================

Name: ula_seq

Overview:
- Multi-cycle ALU that consumes the 4-bit `op` code produced by the ALU control decoder in the execute stage.
- Logic/arithmetic/compare ops complete one edge after start.
- Shifts run one bit per clock using a shift register and down-counter.
- Start/busy/done handshake lets the multicycle control FSM stall on shifts.

Parameters:
WIDTH  32  datapath width; must equal 2**SHW
SHW  5  shift-amount width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy=0
op  input  4  ALU operation code
a  input  WIDTH  operand A (rs); a[SHW-1:0] is the amount for variable shifts
b  input  WIDTH  operand B (rt/imm); the value shifted by all shifts
shamt  input  SHW  amount for fixed shifts
result  output  WIDTH  registered result, held until next accepted start
zero  output  1  result == 0, registered with result
ovf  output  1  signed overflow, add/sub only; 0 otherwise
err  output  1  op was not a legal code
busy  output  1  state != IDLE
done  output  1  one-cycle pulse, state == DONE

Behaviour:
- Reset (async, rst_n=0) sets:
  - outputs: result=0, zero=1, ovf=0, err=0, busy=0, done=0
  - state=IDLE; shift register and counter = 0
  - Reset mid-shift aborts the operation; no done is produced.
- States: IDLE, SHIFT, DONE.
- Accept condition: start=1 at edge E0 while in IDLE. Operands are latched at E0; later input changes are ignored.
- Codes executed at E0; result loaded and state goes to DONE:
  - 0010 add: a+b, wrap modulo 2**WIDTH; ovf = a,b same sign and result sign differs
  - 0110 sub: a-b; ovf = a,b differ in sign and result sign != a sign
  - 0000 and, 0001 or, 1101 xor, 1100 nor (~(a|b))
  - 0111 slt, signed: result = 1 if $signed(a) < $signed(b), else 0
- Shift codes:
  - fixed amount n = shamt: 0011 sll, 0101 srl, 0100 sra
  - variable amount n = a[SHW-1:0]: 1110 sllv, 1111 srlv, 1010 srav
- Shift sequence:
  - E0: load shreg=b, cnt=n.
  - n=0: result=b at E0, go to DONE.
  - n>0: go to SHIFT. Each SHIFT edge shifts one bit and decrements cnt.
    - sll: zero fill at LSB. srl: zero fill at MSB. sra: replicate MSB.
  - The edge that takes cnt to 0 loads result from the shifted value and enters DONE.
- Latency: done is high in the cycle after edge E0+n (n=0 for non-shift codes). Maximum is 31 cycles.
- DONE lasts exactly one cycle, then IDLE. start is ignored in DONE and SHIFT; it is not queued.
- Back-to-back throughput: start may be re-asserted in the cycle after DONE, so at most one accept every 2 cycles.
- Illegal codes (1000, 1001, 1011): result=0, zero=1, err=1, go to DONE at E0.
- err, ovf and zero are updated only when result is loaded and hold until the next load.
- Unsigned compare is not supported; sltu maps to 0111 and gets signed semantics, a known limitation.

Test Plan:
- Add overflow: a=7FFFFFFF, b=00000001, op=0010 -> done 1 cycle after start; result=80000000, ovf=1, zero=0.
- Sub to zero, then slt:
  - a=5, b=5, op=0110 -> result=0, zero=1, ovf=0.
  - a=FFFFFFFF, b=1, op=0111 -> result=1.
- Fixed shift: b=80000000, shamt=4, op=0100 (sra) -> busy high 5 cycles; done after edge E0+4; result=F8000000. Same with op=0101 (srl) -> 08000000.
- Variable shift, edge counts:
  - a=0000001F, b=1, op=1110 (sllv) -> result=80000000 after 31 shift edges.
  - a=00000020 (amount 0), b=1234, op=1111 (srlv) -> result=1234, done at E0.
- Handshake and error:
  - start held high during a 10-bit shift -> exactly one done pulse; second op accepted only after DONE.
  - op=1000 -> err=1, result=0.
- Reset mid-shift: rst_n=0 at cycle 3 of an sll by 20 -> immediate busy=0, result=0, zero=1. No done afterward; a new start after release works normally.

Source files
------------

// File: rtl/ula_seq.sv
// rtl/ula_seq.sv - multi-cycle ALU with one-bit-per-clock shifter and start/busy/done handshake
// Logic, arithmetic and compare ops finish at the accepting edge; shifts step once per clock.
module ula_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             err,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRA  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRAV = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_XOR  = 4'b1101;
  localparam logic [3:0] OP_SLLV = 4'b1110;
  localparam logic [3:0] OP_SRLV = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SH_LL = 2'd0,
    SH_RL = 2'd1,
    SH_RA = 2'd2
  } shkind_t;

  state_t           state_q, state_d;
  shkind_t          kind_q, kind_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] sum, diff, shifted, load_val;
  logic             load_en, load_ovf, load_err;
  logic             is_shift;
  shkind_t          new_kind;
  logic [SHW-1:0]   new_cnt;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    shifted = shreg_q;
    case (kind_q)
      SH_LL:   shifted = {shreg_q[WIDTH-2:0], 1'b0};
      SH_RL:   shifted = {1'b0, shreg_q[WIDTH-1:1]};
      SH_RA:   shifted = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
      default: shifted = shreg_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    load_en  = 1'b0;
    load_val = '0;
    load_ovf = 1'b0;
    load_err = 1'b0;
    is_shift = 1'b0;
    new_kind = SH_LL;
    new_cnt  = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DONE;
          load_en = 1'b1;
          case (op)
            OP_ADD: begin
              load_val = sum;
              load_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
              load_val = diff;
              load_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  load_val = a & b;
            OP_OR:   load_val = a | b;
            OP_XOR:  load_val = a ^ b;
            OP_NOR:  load_val = ~(a | b);
            OP_SLT:  load_val = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL:  begin is_shift = 1'b1; new_kind = SH_LL; new_cnt = shamt;        end
            OP_SRL:  begin is_shift = 1'b1; new_kind = SH_RL; new_cnt = shamt;        end
            OP_SRA:  begin is_shift = 1'b1; new_kind = SH_RA; new_cnt = shamt;        end
            OP_SLLV: begin is_shift = 1'b1; new_kind = SH_LL; new_cnt = a[SHW-1:0];   end
            OP_SRLV: begin is_shift = 1'b1; new_kind = SH_RL; new_cnt = a[SHW-1:0];   end
            OP_SRAV: begin is_shift = 1'b1; new_kind = SH_RA; new_cnt = a[SHW-1:0];   end
            default: load_err = 1'b1;
          endcase
          if (is_shift) begin
            shreg_d  = b;
            cnt_d    = new_cnt;
            kind_d   = new_kind;
            load_val = b;
            // A zero-amount shift completes immediately with the unshifted operand.
            if (new_cnt != '0) begin
              load_en = 1'b0;
              state_d = SHIFT;
            end
          end
        end
      end
      SHIFT: begin
        shreg_d = shifted;
        cnt_d   = cnt_q - {{(SHW-1){1'b0}}, 1'b1};
        if (cnt_q == {{(SHW-1){1'b0}}, 1'b1}) begin
          load_en  = 1'b1;
          load_val = shifted;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    result_d = load_en ? load_val : result_q;
    zero_d   = load_en ? (load_val == '0) : zero_q;
    ovf_d    = load_en ? load_ovf : ovf_q;
    err_d    = load_en ? load_err : err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      kind_q   <= SH_LL;
      shreg_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;
  assign err    = err_q;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_ula_seq.sv
// tb/tb_ula_seq.sv - directed self-checking bench for ula_seq
module tb_ula_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic [4:0]  shamt;
  logic [31:0] result;
  logic        zero, ovf, err, busy, done;

  int checks = 0;
  int errors = 0;
  int lat, busy_cnt, done_cnt;

  ula_seq #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .shamt(shamt),
    .result(result), .zero(zero), .ovf(ovf), .err(err), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, scramble inputs after the accepting edge, wait (bounded) for done.
  task automatic run(input string tag, input logic [3:0] o, input logic [31:0] av,
                     input logic [31:0] bv, input logic [4:0] sh, input int exp_lat);
    op = o; a = av; b = bv; shamt = sh; start = 1'b1;
    step();
    start = 1'b0;
    op = 4'($urandom); a = $urandom; b = $urandom; shamt = 5'($urandom);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      busy_cnt += int'(busy);
      step();
      lat++;
    end
    busy_cnt += int'(busy);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat + 1));
  endtask

  task automatic after_done(input string tag);
    step();
    check({tag, " done_cleared"}, {31'd0, done}, 32'd0);
    check({tag, " idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 4'd0; a = '0; b = '0; shamt = '0;
    step();
    step();
    check("rst result", result, 32'd0);
    check("rst zero", {31'd0, zero}, 32'd1);
    check("rst ovf", {31'd0, ovf}, 32'd0);
    check("rst err", {31'd0, err}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    step();

    run("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 0);
    check("add_ovf result", result, 32'h8000_0000);
    check("add_ovf ovf", {31'd0, ovf}, 32'd1);
    check("add_ovf zero", {31'd0, zero}, 32'd0);
    after_done("add_ovf");

    run("sub_zero", 4'b0110, 32'd5, 32'd5, 5'd0, 0);
    check("sub_zero result", result, 32'd0);
    check("sub_zero zero", {31'd0, zero}, 32'd1);
    check("sub_zero ovf", {31'd0, ovf}, 32'd0);
    after_done("sub_zero");

    run("slt", 4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0, 0);
    check("slt result", result, 32'd1);
    check("slt zero", {31'd0, zero}, 32'd0);
    after_done("slt");

    run("sub_ovf", 4'b0110, 32'h8000_0000, 32'd1, 5'd0, 0);
    check("sub_ovf result", result, 32'h7FFF_FFFF);
    check("sub_ovf ovf", {31'd0, ovf}, 32'd1);
    after_done("sub_ovf");

    run("and", 4'b0000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 0);
    check("and result", result, 32'h00F0_000F);
    check("and ovf", {31'd0, ovf}, 32'd0);
    after_done("and");
    run("or", 4'b0001, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 0);
    check("or result", result, 32'hFFF0_0FFF);
    after_done("or");
    run("xor", 4'b1101, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 0);
    check("xor result", result, 32'hFF00_0FF0);
    after_done("xor");
    run("nor", 4'b1100, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 0);
    check("nor result", result, 32'h000F_F000);
    after_done("nor");

    run("sra4", 4'b0100, 32'h0, 32'h8000_0000, 5'd4, 4);
    check("sra4 result", result, 32'hF800_0000);
    check("sra4 zero", {31'd0, zero}, 32'd0);
    after_done("sra4");
    run("srl4", 4'b0101, 32'h0, 32'h8000_0000, 5'd4, 4);
    check("srl4 result", result, 32'h0800_0000);
    after_done("srl4");
    run("sll0", 4'b0011, 32'h0, 32'hCAFE_0001, 5'd0, 0);
    check("sll0 result", result, 32'hCAFE_0001);
    after_done("sll0");

    run("sllv31", 4'b1110, 32'h0000_001F, 32'd1, 5'd3, 31);
    check("sllv31 result", result, 32'h8000_0000);
    after_done("sllv31");
    run("srlv0", 4'b1111, 32'h0000_0020, 32'h0000_1234, 5'd7, 0);
    check("srlv0 result", result, 32'h0000_1234);
    after_done("srlv0");
    run("srav3", 4'b1010, 32'h0000_0003, 32'hF000_0000, 5'd0, 3);
    check("srav3 result", result, 32'hFE00_0000);
    after_done("srav3");

    run("ill1000", 4'b1000, 32'h1234_5678, 32'h1, 5'd0, 0);
    check("ill1000 err", {31'd0, err}, 32'd1);
    check("ill1000 result", result, 32'd0);
    check("ill1000 zero", {31'd0, zero}, 32'd1);
    after_done("ill1000");
    run("ill1011", 4'b1011, 32'h1, 32'h1, 5'd0, 0);
    check("ill1011 err", {31'd0, err}, 32'd1);
    after_done("ill1011");
    run("err_clear", 4'b0010, 32'd2, 32'd3, 5'd0, 0);
    check("err_clear err", {31'd0, err}, 32'd0);
    check("err_clear result", result, 32'd5);
    after_done("err_clear");

    // start held high through a 10-bit shift: one done, re-accept only after DONE
    op = 4'b0011; a = 32'h0; b = 32'd1; shamt = 5'd10; start = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      done_cnt += int'(done);
      if (i == 10) check("hold shift result", result, 32'h0000_0400);
    end
    check("hold done_pulses", 32'(done_cnt), 32'd1);
    check("hold idle_gap", {31'd0, busy}, 32'd0);
    op = 4'b0010; a = 32'd2; b = 32'd3;
    step();
    start = 1'b0;
    check("hold reaccept done", {31'd0, done}, 32'd1);
    check("hold reaccept result", result, 32'd5);
    step();

    // reset in the middle of an sll by 20
    op = 4'b0011; a = 32'h0; b = 32'd1; shamt = 5'd20; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst result", result, 32'd0);
    check("midrst zero", {31'd0, zero}, 32'd1);
    check("midrst done", {31'd0, done}, 32'd0);
    step();
    #2 rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      done_cnt += int'(done);
    end
    check("midrst no_done", 32'(done_cnt), 32'd0);
    run("post_rst", 4'b1101, 32'hAAAA_5555, 32'hFFFF_FFFF, 5'd0, 0);
    check("post_rst result", result, 32'h5555_AAAA);
    after_done("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
